// File: rtl/branch_history_cache.sv
// 2-way set-associative branch history table: combinational lookup, update-on-resolve,
// pseudo-LRU replacement and a one-set-per-cycle invalidate sweep. Optional stats via BHC_STATS_EN.
module branch_history_cache #(
  parameter int PC_WIDTH    = 10,
  parameter int INDEX_WIDTH = 4,
  parameter int HIST_WIDTH  = 3,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [PC_WIDTH-1:0]    rd_pc,
  output logic                   rd_hit,
  output logic [HIST_WIDTH-1:0]  rd_history,
  input  logic                   upd_we,
  input  logic [PC_WIDTH-1:0]    upd_pc,
  input  logic                   upd_taken,
  output logic                   upd_hit,
  output logic [HIST_WIDTH-1:0]  upd_history,
  output logic                   evict,
  input  logic                   flush_req,
  output logic                   busy
`ifdef BHC_STATS_EN
  ,
  output logic [COUNT_WIDTH-1:0] hit_count,
  output logic [COUNT_WIDTH-1:0] miss_count
`endif
);

  localparam int SETS      = 1 << INDEX_WIDTH;
  localparam int TAG_WIDTH = PC_WIDTH - INDEX_WIDTH;

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t                 state_reg, state_next;
  logic [INDEX_WIDTH-1:0] cnt_reg, cnt_next;

  logic                  valid_reg [2][SETS];
  logic [TAG_WIDTH-1:0]  tag_reg   [2][SETS];
  logic [HIST_WIDTH-1:0] hist_reg  [2][SETS];
  logic                  lru_reg   [SETS];

  logic [INDEX_WIDTH-1:0] rd_set, upd_set;
  logic [TAG_WIDTH-1:0]   rd_tag, upd_tag;
  logic [1:0]             rd_match, upd_match;
  logic                   accept, upd_way;
  logic [HIST_WIDTH-1:0]  hist_new;

  assign rd_set  = rd_pc[INDEX_WIDTH-1:0];
  assign rd_tag  = rd_pc[PC_WIDTH-1:INDEX_WIDTH];
  assign upd_set = upd_pc[INDEX_WIDTH-1:0];
  assign upd_tag = upd_pc[PC_WIDTH-1:INDEX_WIDTH];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_way
      assign rd_match[gi]  = valid_reg[gi][rd_set] && (tag_reg[gi][rd_set] == rd_tag);
      assign upd_match[gi] = valid_reg[gi][upd_set] && (tag_reg[gi][upd_set] == upd_tag);
    end
  endgenerate

  assign busy   = (state_reg == FLUSH);
  assign accept = upd_we && !busy;

  always_comb begin
    rd_hit      = 1'b0;
    rd_history  = '0;
    upd_hit     = 1'b0;
    upd_history = '0;
    evict       = 1'b0;
    if (!busy) begin
      rd_hit = |rd_match;
      if (rd_match[0])      rd_history = hist_reg[0][rd_set];
      else if (rd_match[1]) rd_history = hist_reg[1][rd_set];
      upd_hit = |upd_match;
      if (upd_match[0])      upd_history = hist_reg[0][upd_set];
      else if (upd_match[1]) upd_history = hist_reg[1][upd_set];
      evict = upd_we && !(|upd_match) && valid_reg[0][upd_set] && valid_reg[1][upd_set];
    end
  end

  // upd_history is zero on a miss, so one shift covers both the hit and the fresh-entry case
  assign hist_new = (upd_history << 1) | HIST_WIDTH'(upd_taken);

  always_comb begin
    if (upd_match[1])                 upd_way = 1'b1;
    else if (upd_match[0])            upd_way = 1'b0;
    else if (!valid_reg[0][upd_set])  upd_way = 1'b0;
    else if (!valid_reg[1][upd_set])  upd_way = 1'b1;
    else                              upd_way = lru_reg[upd_set];
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (flush_req) begin
          state_next = FLUSH;
          cnt_next   = '0;
        end
      end
      FLUSH: begin
        cnt_next = cnt_reg + 1'b1;
        if (cnt_reg == '1) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      for (int s = 0; s < SETS; s++) begin
        lru_reg[s] <= 1'b0;
        for (int w = 0; w < 2; w++) begin
          valid_reg[w][s] <= 1'b0;
          tag_reg[w][s]   <= '0;
          hist_reg[w][s]  <= '0;
        end
      end
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (busy) begin
        // Sweep clears only valid and lru; tags and histories are left stale
        valid_reg[0][cnt_reg] <= 1'b0;
        valid_reg[1][cnt_reg] <= 1'b0;
        lru_reg[cnt_reg]      <= 1'b0;
      end else if (accept) begin
        valid_reg[upd_way][upd_set] <= 1'b1;
        tag_reg[upd_way][upd_set]   <= upd_tag;
        hist_reg[upd_way][upd_set]  <= hist_new;
        lru_reg[upd_set]            <= ~upd_way;
      end
    end
  end

`ifdef BHC_STATS_EN
  logic [COUNT_WIDTH-1:0] hit_count_reg, miss_count_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_count_reg  <= '0;
      miss_count_reg <= '0;
    end else if (state_reg == IDLE && flush_req) begin
      hit_count_reg  <= '0;
      miss_count_reg <= '0;
    end else if (accept) begin
      if (upd_hit && hit_count_reg != '1)        hit_count_reg  <= hit_count_reg + 1'b1;
      else if (!upd_hit && miss_count_reg != '1) miss_count_reg <= miss_count_reg + 1'b1;
    end
  end

  assign hit_count  = hit_count_reg;
  assign miss_count = miss_count_reg;
`endif

endmodule

// File: tb/tb_branch_history_cache.sv
// Bench for branch_history_cache: per-set recency-list model checked every cycle, plus directed literal checks.
module tb_branch_history_cache;
  localparam int PW   = 10;
  localparam int IW   = 4;
  localparam int HW   = 3;
  localparam int SETS = 1 << IW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [PW-1:0] rd_pc = '0;
  logic [PW-1:0] upd_pc = '0;
  logic          upd_we = 1'b0;
  logic          upd_taken = 1'b0;
  logic          flush_req = 1'b0;
  logic          rd_hit, upd_hit, evict, busy;
  logic [HW-1:0] rd_history, upd_history;

  int total = 0;
  int bad   = 0;

  branch_history_cache #(.PC_WIDTH(PW), .INDEX_WIDTH(IW), .HIST_WIDTH(HW)) dut (
    .clk(clk), .rst(rst),
    .rd_pc(rd_pc), .rd_hit(rd_hit), .rd_history(rd_history),
    .upd_we(upd_we), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_hit(upd_hit), .upd_history(upd_history), .evict(evict),
    .flush_req(flush_req), .busy(busy)
  );

  always #5 clk = ~clk;

  // Model: each set is a recency list of up to two {tag, history}; index 0 is least recent
  int m_n    [SETS];
  int m_tag  [SETS][2];
  int m_hist [SETS][2];
  int m_busy_left = 0;

  function automatic int m_find(int s, int t);
    for (int i = 0; i < m_n[s]; i++)
      if (m_tag[s][i] == t) return i;
    return -1;
  endfunction

  task automatic m_clear();
    for (int s = 0; s < SETS; s++) m_n[s] = 0;
  endtask

  task automatic m_update(int s, int t, int tk);
    int i, h;
    i = m_find(s, t);
    if (i >= 0) begin
      h = ((m_hist[s][i] << 1) | tk) & ((1 << HW) - 1);
      if (i == 0 && m_n[s] == 2) begin
        m_tag[s][0]  = m_tag[s][1];
        m_hist[s][0] = m_hist[s][1];
      end
      m_tag[s][m_n[s]-1]  = t;
      m_hist[s][m_n[s]-1] = h;
    end else begin
      if (m_n[s] == 2) begin
        m_tag[s][0]  = m_tag[s][1];
        m_hist[s][0] = m_hist[s][1];
      end else begin
        m_n[s]++;
      end
      m_tag[s][m_n[s]-1]  = t;
      m_hist[s][m_n[s]-1] = tk;
    end
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_clear();
      m_busy_left = 0;
    end else if (m_busy_left > 0) begin
      m_busy_left--;
    end else begin
      if (upd_we) m_update(int'(upd_pc[IW-1:0]), int'(upd_pc[PW-1:IW]), int'(upd_taken));
      if (flush_req) begin
        m_clear();
        m_busy_left = SETS;
      end
    end
  end

  task automatic check(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    int  ri, ui, rs, us;
    bit  busy_e;
    busy_e = (m_busy_left > 0);
    rs = int'(rd_pc[IW-1:0]);
    us = int'(upd_pc[IW-1:0]);
    ri = busy_e ? -1 : m_find(rs, int'(rd_pc[PW-1:IW]));
    ui = busy_e ? -1 : m_find(us, int'(upd_pc[PW-1:IW]));
    check("cyc busy", int'(busy), int'(busy_e));
    check("cyc rd_hit", int'(rd_hit), int'(ri >= 0));
    check("cyc rd_history", int'(rd_history), (ri >= 0) ? m_hist[rs][ri] : 0);
    check("cyc upd_hit", int'(upd_hit), int'(ui >= 0));
    check("cyc upd_history", int'(upd_history), (ui >= 0) ? m_hist[us][ui] : 0);
    check("cyc evict", int'(evict), int'(!busy_e && upd_we && ui < 0 && m_n[us] == 2));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic upd(input logic [PW-1:0] pc, input logic tk);
    upd_pc = pc; upd_taken = tk; upd_we = 1'b1;
    $display("upd pc=%h taken=%0d", pc, tk);
    tick();
    upd_we = 1'b0;
  endtask

  task automatic rd_expect(string name, input logic [PW-1:0] pc, int hit, int hist);
    rd_pc = pc;
    #1;
    $display("read pc=%h hit=%0d hist=%0d", pc, rd_hit, rd_history);
    check({name, " hit"}, int'(rd_hit), hit);
    check({name, " hist"}, int'(rd_history), hist);
    tick();
  endtask

  initial begin
    int n, guard;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    rd_pc = 10'h3A5;
    #1;
    check("reset rd_hit", int'(rd_hit), 0);
    check("reset rd_history", int'(rd_history), 0);
    check("reset busy", int'(busy), 0);
    tick();

    upd_pc = 10'h015; upd_taken = 1'b1; upd_we = 1'b1;
    #1;
    check("first upd_hit", int'(upd_hit), 0);
    check("first evict", int'(evict), 0);
    tick();
    upd_we = 1'b0;
    rd_expect("after first upd", 10'h015, 1, 1);

    upd_pc = 10'h015; upd_taken = 1'b0; upd_we = 1'b1;
    #1;
    check("second upd_hit", int'(upd_hit), 1);
    check("second upd_history", int'(upd_history), 1);
    tick();
    upd_we = 1'b0;
    rd_expect("after second upd", 10'h015, 1, 2);

    upd_pc = 10'h025; upd_taken = 1'b1; upd_we = 1'b1;
    #1;
    check("fill way1 evict", int'(evict), 0);
    tick();
    upd_pc = 10'h035; upd_taken = 1'b1;
    #1;
    check("third tag evict", int'(evict), 1);
    tick();
    upd_we = 1'b0;
    rd_expect("evicted 015", 10'h015, 0, 0);
    rd_expect("kept 025", 10'h025, 1, 1);
    rd_expect("new 035", 10'h035, 1, 1);

    upd(10'h040, 1'b1);
    upd(10'h009, 1'b0);
    upd(10'h009, 1'b1);
    rd_expect("set9 before flush", 10'h009, 1, 1);
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    upd_pc = 10'h099; upd_taken = 1'b1; upd_we = 1'b1;
    n = 0; guard = 0;
    while (busy && guard < 64) begin
      n++; guard++;
      tick();
    end
    upd_we = 1'b0;
    $display("flush busy cycles=%0d", n);
    check("flush busy cycles", n, 16);
    rd_expect("post flush 040", 10'h040, 0, 0);
    rd_expect("post flush 009", 10'h009, 0, 0);
    rd_expect("post flush 035", 10'h035, 0, 0);
    rd_expect("ignored upd 099", 10'h099, 0, 0);

    upd(10'h0AA, 1'b1);
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    repeat (7) tick();
    rst = 1'b0;
    rd_pc = 10'h0AA; upd_pc = 10'h0AA; upd_we = 1'b1;
    #1;
    $display("reset mid-flush busy=%0d", busy);
    check("midflush rst busy", int'(busy), 0);
    check("midflush rst rd_hit", int'(rd_hit), 0);
    check("midflush rst upd_hit", int'(upd_hit), 0);
    check("midflush rst evict", int'(evict), 0);
    tick();
    upd_we = 1'b0;
    rst = 1'b1;
    tick();
    upd(10'h123, 1'b1);
    rd_expect("after rst 123", 10'h123, 1, 1);
    rd_expect("after rst 0AA", 10'h0AA, 0, 0);

    for (int k = 0; k < 600; k++) begin
      rd_pc     = PW'(($urandom_range(0, 2) << IW) | $urandom_range(0, 2));
      upd_pc    = PW'(($urandom_range(0, 2) << IW) | $urandom_range(0, 2));
      upd_we    = ($urandom_range(0, 2) != 0);
      upd_taken = 1'($urandom_range(0, 1));
      flush_req = ($urandom_range(0, 99) == 0);
      if (upd_we || flush_req)
        $display("rand upd_we=%0d pc=%h taken=%0d flush=%0d", upd_we, upd_pc, upd_taken, flush_req);
      tick();
    end
    upd_we = 1'b0;
    flush_req = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
